// File: rtl/reset_sequencer_if.sv
// Control/status bundle for reset_sequencer.
// master: the block driving requests/acks and observing the domain resets.
// slave : the sequencer itself.
interface reset_sequencer_if #(
  parameter int NUM_DOMAINS = 4
);
  logic                   sw_rst_req;   // one-cycle restart pulse
  logic [NUM_DOMAINS-1:0] domain_rdy;   // per-domain ready ack, level
  logic [NUM_DOMAINS-1:0] out_rst;      // per-domain reset, active-high
  logic                   seq_busy;
  logic                   seq_done;
  logic                   timeout_err;  // sticky

  modport master (
    output sw_rst_req, domain_rdy,
    input  out_rst, seq_busy, seq_done, timeout_err
  );

  modport slave (
    input  sw_rst_req, domain_rdy,
    output out_rst, seq_busy, seq_done, timeout_err
  );
endinterface

// File: rtl/reset_sequencer.sv
// Ordered reset-release controller. Holds every domain in reset for
// HOLD_CYCLES, then releases domains one at a time in index order, waiting
// for each domain's ready ack plus GAP_CYCLES before releasing the next.
// Optional feature macro: RESET_SEQ_TIMEOUT_EN -- bounds the ready wait to
// TIMEOUT_CYCLES and flags a sticky timeout error when it expires.
// All outputs are registered; nothing combinational reaches the ports.
module reset_sequencer #(
  parameter int NUM_DOMAINS    = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  reset_sequencer_if.slave     sbus
);

  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam int MAX_T = (HOLD_CYCLES > GAP_CYCLES)
                       ? ((HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES)
                       : ((GAP_CYCLES  > TIMEOUT_CYCLES) ? GAP_CYCLES  : TIMEOUT_CYCLES);

  // Terminal counts (counter starts at 0, so terminal is N-1).
  localparam logic [CNT_WIDTH-1:0] HOLD_T = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_T  = CNT_WIDTH'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  // Counter never wraps: it stops at the largest terminal value in use.
  localparam logic [CNT_WIDTH-1:0] SAT_T  = CNT_WIDTH'(MAX_T - 1);
  localparam logic [IDX_W-1:0]     LAST_I = IDX_W'(NUM_DOMAINS - 1);

  typedef enum logic [1:0] {
    S_ASSERT   = 2'd0,
    S_WAIT_RDY = 2'd1,
    S_GAP      = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [IDX_W-1:0]       r_idx, w_idx_nxt;
  logic [NUM_DOMAINS-1:0] r_out_rst, w_out_rst_nxt;
  logic                   r_busy, r_done;
  logic                   w_busy_nxt, w_done_nxt;
  logic                   w_rdy, w_to_end, w_advance, w_release, w_restart;

  assign w_restart = sbus.sw_rst_req;
  assign w_rdy     = sbus.domain_rdy[r_idx];
  assign w_cnt_inc = (r_cnt >= SAT_T) ? r_cnt : r_cnt + CNT_WIDTH'(1);

`ifdef RESET_SEQ_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] TO_T = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  logic r_err, w_err_nxt;

  assign w_to_end = (r_state == S_WAIT_RDY) && (r_cnt == TO_T);
  // A timeout only counts as an error when ready did not arrive in the
  // same cycle, and a simultaneous restart request takes priority.
  assign w_err_nxt = r_err | (w_to_end & ~w_rdy & ~w_restart);

  // Sticky timeout flag; only a hard reset clears it.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_err <= 1'b0;
    else       r_err <= w_err_nxt;
  end

  assign sbus.timeout_err = r_err;
`else
  assign w_to_end         = 1'b0;
  assign sbus.timeout_err = 1'b0;
`endif

  // Timeout expiry behaves exactly like a sampled ready.
  assign w_advance = w_rdy | w_to_end;

  // State register plus all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_ASSERT;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_out_rst <= '1;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_out_rst <= w_out_rst_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Next-state logic; w_release marks the cycle a domain (w_idx_nxt) is freed.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_release   = 1'b0;
    if (w_restart) begin
      w_state_nxt = S_ASSERT;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end else begin
      unique case (r_state)
        S_ASSERT: begin
          if (r_cnt == HOLD_T) begin
            w_state_nxt = S_WAIT_RDY;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_release   = 1'b1;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end
        S_WAIT_RDY: begin
          if (w_advance) begin
            w_cnt_nxt = '0;
            if (r_idx == LAST_I) begin
              w_state_nxt = S_DONE;
            end else if (GAP_CYCLES == 0) begin
              // No gap: release the next domain straight away.
              w_idx_nxt   = r_idx + IDX_W'(1);
              w_release   = 1'b1;
            end else begin
              w_state_nxt = S_GAP;
            end
          end else begin
`ifdef RESET_SEQ_TIMEOUT_EN
            w_cnt_nxt = w_cnt_inc;
`else
            w_cnt_nxt = r_cnt;
`endif
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_T) begin
            w_state_nxt = S_WAIT_RDY;
            w_cnt_nxt   = '0;
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_release   = 1'b1;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end
        S_DONE: begin
          // Ready dropping here is deliberately ignored.
          w_state_nxt = S_DONE;
        end
        default: begin
          w_state_nxt = S_ASSERT;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  // Output next-values: busy/done follow the state being entered.
  always_comb begin
    w_busy_nxt = (w_state_nxt != S_DONE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // Per-domain reset bit: only the domain being released can fall, and
  // a restart re-asserts every domain at once.
  for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_dom
    assign w_out_rst_nxt[d] = w_restart |
      (r_out_rst[d] & ~(w_release & (w_idx_nxt == IDX_W'(d))));
  end

  assign sbus.out_rst  = r_out_rst;
  assign sbus.seq_busy = r_busy;
  assign sbus.seq_done = r_done;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized scoreboard bench for reset_sequencer. Two instances (with and
// without a release gap) run side by side against a countdown model.
module tb_reset_sequencer;
  localparam int N = 4;
  localparam int HOLD_A = 16, GAP_A = 8, TO_A = 10;
  localparam int HOLD_B = 3,  GAP_B = 0, TO_B = 6;
`ifdef RESET_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    int n_rel;    // domains released so far
    int tmr;      // cycles left before the next release (hold/gap)
    bit waiting;  // waiting for ready of domain n_rel-1
    int wcnt;     // cycles spent waiting
    bit done;
    bit err;
  } mdl_t;

  typedef struct {
    logic [N-1:0] ors;
    logic bsy, dn, er;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw  = 1'b0;
  logic [N-1:0] rdy_a = '0, rdy_b = '0;
  int checks = 0, errors = 0;
  int ecnt = 0;
  bit rec = 1'b0;
  int fall[2][N];
  int done_e[2];
  logic [N-1:0] prev[2];
  mdl_t m[2];
  exp_t q0[$], q1[$];

  always #5 clk = ~clk;

  reset_sequencer_if #(.NUM_DOMAINS(N)) ifa();
  reset_sequencer_if #(.NUM_DOMAINS(N)) ifb();

  assign ifa.sw_rst_req = sw;
  assign ifa.domain_rdy = rdy_a;
  assign ifb.sw_rst_req = sw;
  assign ifb.domain_rdy = rdy_b;

  reset_sequencer #(.NUM_DOMAINS(N), .HOLD_CYCLES(HOLD_A), .GAP_CYCLES(GAP_A),
                    .TIMEOUT_CYCLES(TO_A), .CNT_WIDTH(8))
    dut_a (.i_clk(clk), .i_rst(rst), .sbus(ifa.slave));

  reset_sequencer #(.NUM_DOMAINS(N), .HOLD_CYCLES(HOLD_B), .GAP_CYCLES(GAP_B),
                    .TIMEOUT_CYCLES(TO_B), .CNT_WIDTH(4))
    dut_b (.i_clk(clk), .i_rst(rst), .sbus(ifb.slave));

  // Edges since the last edge that sampled reset high.
  always @(posedge clk) ecnt <= rst ? 0 : ecnt + 1;

  function automatic mdl_t step(mdl_t s, bit r, bit w, logic [N-1:0] rd,
                                int hold, int gap, int to);
    mdl_t n = s;
    bit ok, tmo;
    if (r || w) begin
      n.n_rel = 0; n.tmr = hold; n.waiting = 0; n.wcnt = 0; n.done = 0;
      if (r) n.err = 0;
    end else if (s.done) begin
      n = s;
    end else if (s.waiting) begin
      n.wcnt = s.wcnt + 1;
      ok  = rd[s.n_rel-1];
      tmo = TO_EN && (n.wcnt >= to);
      if (ok || tmo) begin
        if (!ok) n.err = 1;
        n.waiting = 0;
        if (s.n_rel == N) n.done = 1;
        else if (gap == 0) begin
          n.n_rel = s.n_rel + 1; n.waiting = 1; n.wcnt = 0;
        end else n.tmr = gap;
      end
    end else begin
      n.tmr = s.tmr - 1;
      if (n.tmr == 0) begin
        n.n_rel = s.n_rel + 1; n.waiting = 1; n.wcnt = 0;
      end
    end
    return n;
  endfunction

  function automatic exp_t mk(mdl_t s);
    exp_t e;
    for (int k = 0; k < N; k++) e.ors[k] = (k >= s.n_rel);
    e.bsy = !s.done;
    e.dn  = s.done;
    e.er  = s.err;
    return e;
  endfunction

  function automatic logic [N-1:0] srand();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = ($urandom_range(0, 5) == 0);
    return v;
  endfunction

  task automatic chk(string nm, int got, int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at t=%0t", nm, got, want, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue the response it must produce.
  task automatic cyc(bit r, bit w, logic [N-1:0] ra, logic [N-1:0] rb);
    @(negedge clk);
    rst = r; sw = w; rdy_a = ra; rdy_b = rb;
    m[0] = step(m[0], r, w, ra, HOLD_A, GAP_A, TO_A);
    m[1] = step(m[1], r, w, rb, HOLD_B, GAP_B, TO_B);
    q0.push_back(mk(m[0]));
    q1.push_back(mk(m[1]));
  endtask

  task automatic mon(int i, exp_t e, logic [N-1:0] o, logic b, logic d, logic er);
    string s = (i == 0) ? "a" : "b";
    chk({"out_rst_", s},     int'(o),  int'(e.ors));
    chk({"seq_busy_", s},    int'(b),  int'(e.bsy));
    chk({"seq_done_", s},    int'(d),  int'(e.dn));
    chk({"timeout_err_", s}, int'(er), int'(e.er));
    if (rec) begin
      for (int k = 0; k < N; k++)
        if (fall[i][k] < 0 && prev[i][k] === 1'b1 && o[k] === 1'b0) fall[i][k] = ecnt;
      if (done_e[i] < 0 && d === 1'b1) done_e[i] = ecnt;
    end
    prev[i] = o;
  endtask

  // Monitor: compare whatever the DUTs present against the queued responses.
  initial forever begin
    @(posedge clk);
    #2;
    if (q0.size() > 0) mon(0, q0.pop_front(), ifa.out_rst, ifa.seq_busy, ifa.seq_done, ifa.timeout_err);
    if (q1.size() > 0) mon(1, q1.pop_front(), ifb.out_rst, ifb.seq_busy, ifb.seq_done, ifb.timeout_err);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      m[i] = '{n_rel: 0, tmr: 0, waiting: 0, wcnt: 0, done: 0, err: 0};
      done_e[i] = -1;
      prev[i] = '1;
      for (int k = 0; k < N; k++) fall[i][k] = -1;
    end

    repeat (3) cyc(1'b1, 1'b0, srand(), srand());

    // All ready from the start: absolute release timing.
    rec = 1'b1;
    repeat (60) cyc(1'b0, 1'b0, '1, '1);
    rec = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("release_edge_a%0d", k), fall[0][k], HOLD_A + k * (GAP_A + 1));
      chk($sformatf("release_edge_b%0d", k), fall[1][k], HOLD_B + k * (GAP_B + 1));
    end
    chk("done_edge_a", done_e[0], HOLD_A + (N - 1) * (GAP_A + 1) + 1);
    chk("done_edge_b", done_e[1], HOLD_B + (N - 1) * (GAP_B + 1) + 1);

    // Restart, then domain 1 stalls for a long time.
    cyc(1'b0, 1'b1, '1, '1);
    repeat (150) cyc(1'b0, 1'b0, 4'b1101, 4'b1101);
    repeat (40)  cyc(1'b0, 1'b0, '1, '1);

    // Domain 2 never ready, then restart (error survives) and hard reset.
    cyc(1'b0, 1'b1, 4'b1011, 4'b1011);
    repeat (120) cyc(1'b0, 1'b0, 4'b1011, 4'b1011);
    cyc(1'b0, 1'b1, '0, '0);
    repeat (5) cyc(1'b0, 1'b0, '0, '0);
    cyc(1'b1, 1'b0, '0, '0);

    // Restart held high for several cycles.
    repeat (4) cyc(1'b0, 1'b1, '1, '1);
    repeat (30) cyc(1'b0, 1'b0, srand(), srand());

    // Random soak with occasional restarts and resets.
    for (int i = 0; i < 2500; i++) begin
      logic r, w;
      logic [N-1:0] ra, rb;
      r  = ($urandom_range(0, 299) == 0);
      w  = ($urandom_range(0, 99) == 0);
      ra = ($urandom_range(0, 9) == 0) ? '1 : srand();
      rb = ($urandom_range(0, 9) == 0) ? '1 : srand();
      cyc(r, w, ra, rb);
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q0.size() + q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
